// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: advances on the pixel strobe (a clock enable on clk).
// Sync/video/pulse outputs are registered together with the counters and share their edge.
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter bit          SYNC_POL = 1'b0
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       pix_en,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic [9:0] hcount,
  output logic [9:0] vcount,
  output logic       line_start,
  output logic       frame_start
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST  = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST  = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT   = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT   = 10'(V_ACTIVE);
  localparam logic [9:0] HS_BEG  = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END  = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_BEG  = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END  = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic [9:0] hcount_q, hcount_d;
  logic [9:0] vcount_q, vcount_d;
  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;
  logic       video_on_q, video_on_d;
  logic       line_start_q, frame_start_q;
  logic       h_wrap, v_wrap;

  // Decode from the next counter values so outputs line up with the counters.
  always_comb begin
    h_wrap     = (hcount_q == H_LAST);
    v_wrap     = (vcount_q == V_LAST);
    hcount_d   = h_wrap ? 10'd0 : hcount_q + 10'd1;
    vcount_d   = vcount_q;
    if (h_wrap) begin
      vcount_d = v_wrap ? 10'd0 : vcount_q + 10'd1;
    end
    hsync_d    = ((hcount_d >= HS_BEG) && (hcount_d < HS_END)) ? SYNC_POL : ~SYNC_POL;
    vsync_d    = ((vcount_d >= VS_BEG) && (vcount_d < VS_END)) ? SYNC_POL : ~SYNC_POL;
    video_on_d = (hcount_d < H_ACT) && (vcount_d < V_ACT);
  end

  // Reset parks on the last pixel so the first strobe lands on (0, 0).
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      hcount_q      <= H_LAST;
      vcount_q      <= V_LAST;
      hsync_q       <= ~SYNC_POL;
      vsync_q       <= ~SYNC_POL;
      video_on_q    <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      if (pix_en) begin
        hcount_q      <= hcount_d;
        vcount_q      <= vcount_d;
        hsync_q       <= hsync_d;
        vsync_q       <= vsync_d;
        video_on_q    <= video_on_d;
        line_start_q  <= h_wrap;
        frame_start_q <= h_wrap && v_wrap;
      end
    end
  end

  assign hcount      = hcount_q;
  assign vcount      = vcount_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign video_on    = video_on_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: full-size 640x480 instance plus a shrunken active-high-sync instance.
module tb_vga_timing_gen;

  typedef struct packed {
    logic       hs;
    logic       vs;
    logic       von;
    logic [9:0] h;
    logic [9:0] v;
    logic       ls;
    logic       fs;
  } obs_t;

  typedef struct {
    int ht, hact, hfp, hsw;
    int vt, vact, vfp, vsw;
    bit pol;
  } geom_t;

  typedef struct {
    logic       en;
    logic [9:0] h;
    logic [9:0] v;
    logic       von, hs, vs, ls, fs;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       clr_a, pix_en_a, hsync_a, vsync_a, video_on_a, line_start_a, frame_start_a;
  logic [9:0] hcount_a, vcount_a;
  logic       clr_b, pix_en_b, hsync_b, vsync_b, video_on_b, line_start_b, frame_start_b;
  logic [9:0] hcount_b, vcount_b;

  vga_timing_gen u_dut_a (
    .clk(clk), .clr(clr_a), .pix_en(pix_en_a),
    .hsync(hsync_a), .vsync(vsync_a), .video_on(video_on_a),
    .hcount(hcount_a), .vcount(vcount_a),
    .line_start(line_start_a), .frame_start(frame_start_a)
  );

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(3),
    .SYNC_POL(1'b1)
  ) u_dut_b (
    .clk(clk), .clr(clr_b), .pix_en(pix_en_b),
    .hsync(hsync_b), .vsync(vsync_b), .video_on(video_on_b),
    .hcount(hcount_b), .vcount(vcount_b),
    .line_start(line_start_b), .frame_start(frame_start_b)
  );

  obs_t obs_a, obs_b;
  assign obs_a = {hsync_a, vsync_a, video_on_a, hcount_a, vcount_a, line_start_a, frame_start_a};
  assign obs_b = {hsync_b, vsync_b, video_on_b, hcount_b, vcount_b, line_start_b, frame_start_b};

  geom_t ga = '{800, 640, 16, 96, 525, 480, 10, 2, 1'b0};
  geom_t gb = '{15, 8, 2, 3, 13, 6, 2, 2, 1'b1};

  int    n_cmp = 0;
  int    n_bad = 0;
  longint ka = 0, kb = 0;   // strobes accepted since last reset
  bit    sa = 0, sb = 0;    // last edge carried a strobe

  // Expected outputs after k strobes: raster position is (k-1) mod frame size.
  function automatic obs_t model(geom_t g, longint k, bit strobed);
    obs_t o;
    int   p, h, v;
    if (k == 0) begin
      o = '{hs: ~g.pol, vs: ~g.pol, von: 1'b0, h: 10'(g.ht - 1), v: 10'(g.vt - 1), ls: 1'b0, fs: 1'b0};
      return o;
    end
    p     = int'((k - 1) % longint'(g.ht * g.vt));
    h     = p % g.ht;
    v     = p / g.ht;
    o.h   = 10'(h);
    o.v   = 10'(v);
    o.von = (h < g.hact) && (v < g.vact);
    o.hs  = (h >= g.hact + g.hfp && h < g.hact + g.hfp + g.hsw) ? g.pol : ~g.pol;
    o.vs  = (v >= g.vact + g.vfp && v < g.vact + g.vfp + g.vsw) ? g.pol : ~g.pol;
    o.ls  = strobed && (h == 0);
    o.fs  = strobed && (h == 0) && (v == 0);
    return o;
  endfunction

  task automatic check(input string name, input obs_t act, input obs_t exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got h=%0d v=%0d hs=%b vs=%b von=%b ls=%b fs=%b, want h=%0d v=%0d hs=%b vs=%b von=%b ls=%b fs=%b",
               name, act.h, act.v, act.hs, act.vs, act.von, act.ls, act.fs,
               exp.h, exp.v, exp.hs, exp.vs, exp.von, exp.ls, exp.fs);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic tick_a(input logic en);
    pix_en_a = en;
    @(posedge clk);
    #1;
    if (en) ka++;
    sa = en;
    check("a_model", obs_a, model(ga, ka, sa));
  endtask

  task automatic tick_b(input logic en);
    pix_en_b = en;
    @(posedge clk);
    #1;
    if (en) kb++;
    sb = en;
    check("b_model", obs_b, model(gb, kb, sb));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t  tbl[8];
    obs_t  saved, exp_v;
    int    hs_cnt, von_fall, guard, fs_cnt, vs_cnt, hsb_cnt, ls_cnt;
    logic  prev_von;

    tbl[0] = '{1'b1, 10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    tbl[1] = '{1'b0, 10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[2] = '{1'b0, 10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[3] = '{1'b0, 10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[4] = '{1'b1, 10'd1, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[5] = '{1'b1, 10'd2, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[6] = '{1'b0, 10'd2, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[7] = '{1'b1, 10'd3, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

    clr_a = 1'b1; clr_b = 1'b1; pix_en_a = 1'b0; pix_en_b = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("a_reset", obs_a, '{hs: 1'b1, vs: 1'b1, von: 1'b0, h: 10'd799, v: 10'd524, ls: 1'b0, fs: 1'b0});
    check("b_reset", obs_b, '{hs: 1'b0, vs: 1'b0, von: 1'b0, h: 10'd14, v: 10'd12, ls: 1'b0, fs: 1'b0});
    clr_a = 1'b0;
    #2;
    check("a_release", obs_a, '{hs: 1'b1, vs: 1'b1, von: 1'b0, h: 10'd799, v: 10'd524, ls: 1'b0, fs: 1'b0});

    // Directed vectors from reset release.
    for (int i = 0; i < 8; i++) begin
      tick_a(tbl[i].en);
      exp_v = '{hs: tbl[i].hs, vs: tbl[i].vs, von: tbl[i].von, h: tbl[i].h, v: tbl[i].v,
                ls: tbl[i].ls, fs: tbl[i].fs};
      check($sformatf("a_vec%0d", i), obs_a, exp_v);
    end

    // One line at a strobe every 4th clk, through the wrap into line 1.
    hs_cnt = 0; von_fall = -1; guard = 0; prev_von = video_on_a;
    while (ka < 801 && guard < 2000) begin
      repeat (3) tick_a(1'b0);
      tick_a(1'b1);
      if (vcount_a == 10'd0 && hsync_a == 1'b0) hs_cnt++;
      if (prev_von && !video_on_a && von_fall < 0) von_fall = int'(hcount_a);
      prev_von = video_on_a;
      guard++;
    end
    check_int("line_hsync_strobes", hs_cnt, 96);
    check_int("video_on_fall_h", von_fall, 640);
    check_int("wrap_h", int'(hcount_a), 0);
    check_int("wrap_v", int'(vcount_a), 1);
    check_int("wrap_line_start", int'(line_start_a), 1);
    check_int("wrap_frame_start", int'(frame_start_a), 0);

    // Stall 100 clks at hcount 300.
    guard = 0;
    while (hcount_a != 10'd300 && guard < 1000) begin
      tick_a(1'b1);
      guard++;
    end
    check_int("reach_h300", int'(hcount_a), 300);
    saved = obs_a;
    for (int i = 0; i < 100; i++) begin
      tick_a(1'b0);
      check("hold", obs_a, saved);
    end
    tick_a(1'b1);
    check_int("resume_h301", int'(hcount_a), 301);

    // Random strobe pattern against the model.
    for (int i = 0; i < 2000; i++) tick_a(1'($urandom_range(0, 1)));

    // Async reset mid-line at hcount 700.
    guard = 0;
    while (hcount_a != 10'd700 && guard < 1000) begin
      tick_a(1'b1);
      guard++;
    end
    check_int("reach_h700", int'(hcount_a), 700);
    pix_en_a = 1'b0;
    #2 clr_a = 1'b1;
    #1;
    ka = 0; sa = 0;
    check("a_async_clr", obs_a, model(ga, 0, 0));
    @(posedge clk);
    #3 clr_a = 1'b0;
    tick_a(1'b1);
    check_int("a_after_clr_fs", int'(frame_start_a), 1);

    // Small instance: pix_en tied high, active-high syncs, three full frames.
    clr_b = 1'b0;
    #2;
    check("b_release", obs_b, model(gb, 0, 0));
    fs_cnt = 0; vs_cnt = 0; hsb_cnt = 0; ls_cnt = 0;
    for (int i = 0; i < 3 * 195; i++) begin
      tick_b(1'b1);
      if (frame_start_b) fs_cnt++;
      if (line_start_b) ls_cnt++;
      if (vsync_b) vs_cnt++;
      if (hsync_b) hsb_cnt++;
    end
    check_int("b_frame_starts", fs_cnt, 3);
    check_int("b_line_starts", ls_cnt, 39);
    check_int("b_vsync_clks", vs_cnt, 90);
    check_int("b_hsync_clks", hsb_cnt, 117);

    // Reset during vsync/hsync, then restart at (0, 0).
    guard = 0;
    while (!(hcount_b == 10'd12 && vcount_b == 10'd8) && guard < 400) begin
      tick_b(1'b1);
      guard++;
    end
    check_int("b_reach_12_8", int'(hcount_b) * 100 + int'(vcount_b), 1208);
    check_int("b_syncs_asserted", int'({hsync_b, vsync_b}), 3);
    #2 clr_b = 1'b1;
    #1;
    kb = 0; sb = 0;
    check("b_async_clr", obs_b, model(gb, 0, 0));
    repeat (2) @(posedge clk);
    #3 clr_b = 1'b0;
    #1;
    check("b_no_partial_pulse", obs_b, model(gb, 0, 0));
    tick_b(1'b1);
    check("b_restart", obs_b, '{hs: 1'b0, vs: 1'b0, von: 1'b1, h: 10'd0, v: 10'd0, ls: 1'b1, fs: 1'b1});
    tick_b(1'b1);
    check_int("b_pulse_drop", int'({line_start_b, frame_start_b}), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
